// File: rtl/object_mask_analyzer.sv
// object_mask_analyzer
// Consumes a raster-order 1-bit object mask stream. It accumulates the per-frame
// object pixel count and bounding box, then publishes them over valid/ready.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pix_valid, sof           beat qualifier, start of frame (marks pixel (0,0))
//   object_image             mask bit, 1 = object pixel
//   result_valid/_ready      result handshake
//   pix_count, x_/y_min/max  published frame features
//   obj_present              pix_count >= MIN_PIXELS
//   frame_overrun            pulse: finished frame dropped, previous result unaccepted
//   sync_err                 pulse: sof arrived mid-frame, partial frame aborted
module object_mask_analyzer #(
  parameter int unsigned IMG_WIDTH  = 160,
  parameter int unsigned IMG_HEIGHT = 120,
  parameter int unsigned MIN_PIXELS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  input  logic        sof,
  input  logic        object_image,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [14:0] pix_count,
  output logic [7:0]  x_min,
  output logic [7:0]  x_max,
  output logic [6:0]  y_min,
  output logic [6:0]  y_max,
  output logic        obj_present,
  output logic        frame_overrun,
  output logic        sync_err
);

  localparam int unsigned CW   = 8;
  localparam int unsigned RW   = 7;
  localparam int unsigned NW   = 15;
  localparam int unsigned NPIX = IMG_WIDTH * IMG_HEIGHT;

  typedef enum logic {IDLE, SCAN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [RW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic          done_q, done_d;

  logic          rv_q, rv_d;
  logic [NW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] out_xmin_q, out_xmin_d, out_xmax_q, out_xmax_d;
  logic [RW-1:0] out_ymin_q, out_ymin_d, out_ymax_q, out_ymax_d;
  logic          present_q, present_d;
  logic          overrun_q, overrun_d;
  logic          sync_err_q, sync_err_d;

  // Working values for the current beat: a sof beat starts from the init values.
  logic          start, beat, last;
  logic [CW-1:0] pc, xmin_b, xmax_b;
  logic [RW-1:0] pr, ymin_b, ymax_b;
  logic [NW-1:0] cnt_b;

  // Next-state: scan accumulators and result register
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    xmin_d     = xmin_q;
    xmax_d     = xmax_q;
    ymin_d     = ymin_q;
    ymax_d     = ymax_q;
    done_d     = 1'b0;
    sync_err_d = 1'b0;
    overrun_d  = 1'b0;
    rv_d       = rv_q && !result_ready;
    out_cnt_d  = out_cnt_q;
    out_xmin_d = out_xmin_q;
    out_xmax_d = out_xmax_q;
    out_ymin_d = out_ymin_q;
    out_ymax_d = out_ymax_q;
    present_d  = present_q;

    start = pix_valid && sof;
    beat  = pix_valid && (sof || (state_q == SCAN));

    if (start) begin
      cnt_b  = '0;
      xmin_b = CW'(IMG_WIDTH - 1);
      xmax_b = '0;
      ymin_b = RW'(IMG_HEIGHT - 1);
      ymax_b = '0;
      pc     = '0;
      pr     = '0;
    end else begin
      cnt_b  = cnt_q;
      xmin_b = xmin_q;
      xmax_b = xmax_q;
      ymin_b = ymin_q;
      ymax_b = ymax_q;
      pc     = col_q;
      pr     = row_q;
    end

    last = (pc == CW'(IMG_WIDTH - 1)) && (pr == RW'(IMG_HEIGHT - 1));

    if (beat) begin
      sync_err_d = start && (state_q == SCAN);
      cnt_d  = cnt_b;
      xmin_d = xmin_b;
      xmax_d = xmax_b;
      ymin_d = ymin_b;
      ymax_d = ymax_b;
      if (object_image) begin
        if (cnt_b != NW'(NPIX)) cnt_d = cnt_b + NW'(1);
        if (pc < xmin_b) xmin_d = pc;
        if (pc > xmax_b) xmax_d = pc;
        if (pr < ymin_b) ymin_d = pr;
        if (pr > ymax_b) ymax_d = pr;
      end
      if (pc == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = last ? '0 : pr + RW'(1);
      end else begin
        col_d = pc + CW'(1);
        row_d = pr;
      end
      // Leaving SCAN on the last pixel lets a sof on the very next beat start cleanly.
      state_d = last ? IDLE : SCAN;
      done_d  = last;
    end

    // Publish one cycle after the last pixel; accumulators still hold the finished frame.
    if (done_q) begin
      if (rv_q && !result_ready) begin
        overrun_d = 1'b1;
      end else begin
        rv_d      = 1'b1;
        out_cnt_d = cnt_q;
        present_d = (cnt_q != '0) && (cnt_q >= NW'(MIN_PIXELS));
        if (cnt_q == '0) begin
          out_xmin_d = '0;
          out_xmax_d = '0;
          out_ymin_d = '0;
          out_ymax_d = '0;
        end else begin
          out_xmin_d = xmin_q;
          out_xmax_d = xmax_q;
          out_ymin_d = ymin_q;
          out_ymax_d = ymax_q;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymin_q     <= '0;
      ymax_q     <= '0;
      done_q     <= 1'b0;
      rv_q       <= 1'b0;
      out_cnt_q  <= '0;
      out_xmin_q <= '0;
      out_xmax_q <= '0;
      out_ymin_q <= '0;
      out_ymax_q <= '0;
      present_q  <= 1'b0;
      overrun_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      xmin_q     <= xmin_d;
      xmax_q     <= xmax_d;
      ymin_q     <= ymin_d;
      ymax_q     <= ymax_d;
      done_q     <= done_d;
      rv_q       <= rv_d;
      out_cnt_q  <= out_cnt_d;
      out_xmin_q <= out_xmin_d;
      out_xmax_q <= out_xmax_d;
      out_ymin_q <= out_ymin_d;
      out_ymax_q <= out_ymax_d;
      present_q  <= present_d;
      overrun_q  <= overrun_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign result_valid  = rv_q;
  assign pix_count     = out_cnt_q;
  assign x_min         = out_xmin_q;
  assign x_max         = out_xmax_q;
  assign y_min         = out_ymin_q;
  assign y_max         = out_ymax_q;
  assign obj_present   = present_q;
  assign frame_overrun = overrun_q;
  assign sync_err      = sync_err_q;

endmodule
